fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage next-PC selector, PC register and F/D pipeline register for the 5-stage MIPS core.
- Consumes the branch predictor's PCControls/PCCache; produces PCF (predictor lookup index) and PCD/HitD (predictor update context).
- Applies decode-stage corrections (mispredicted taken, unpredicted branch/jump) by redirecting fetch and squashing the wrongly fetched instruction in F/D.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into F/D on squash.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- StallF  input  1  hold PCF (hazard unit).
- StallD  input  1  hold F/D register (hazard unit).
- FlushD  input  1  external F/D squash (hazard unit).
- PCControls  input  4  from predictor: [3] predicted-taken-not-taken, [2] unpredicted taken branch, [1] unpredicted jump, [0] HitF.
- PCCache  input  32  predicted target for PCF.
- PCBranchD  input  32  decode branch target.
- PCJumpD  input  32  decode jump target.
- InstrF  input  32  instruction memory data for PCF.
- PCF  output  32  current fetch PC.
- PCPlus4F  output  32  PCF + 4.
- InstrD  output  32  decode instruction.
- PCD  output  32  decode PC.
- PCPlus4D  output  32  PCD + 4.
- HitD  output  1  predictor hit recorded with the instruction in D.
- ValidD  output  1  D holds a real (non-squashed) instruction.
- RedirectD  output  1  decode correction taken this cycle.

Behaviour:
- Reset (async): PCF=RESET_PC; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; HitD=0; ValidD=0. RedirectD is combinational and evaluates 0 out of reset, since all decode state is invalid.
- Correction valid only when ValidD=1 and StallD=0. The corrections are c3=PCControls[3], c2=PCControls[2] and c1=PCControls[1], each gated by that condition. RedirectD = c3|c2|c1.
- Next-PC priority (highest first):
  - c3 -> PCPlus4D.
  - c2 -> PCBranchD.
  - c1 -> PCJumpD.
  - PCControls[0] (HitF) -> PCCache.
  - Otherwise PCPlus4F.
- PCF update:
  - RedirectD=1 -> PCF loads the corrected target even if StallF=1. Corrections override the stall.
  - Else if StallF=0 -> PCF loads the next PC.
  - Else hold.
- F/D register update, first match wins:
  - RedirectD=1 or FlushD=1 -> squash: InstrD=NOP_INSTR, HitD=0, ValidD=0, PCD=0, PCPlus4D=0.
  - StallD=1 -> hold all fields.
  - Otherwise capture InstrF, PCF, PCPlus4F, HitD<=PCControls[0], ValidD<=1.
- Squashed slots carry HitD=0 so the predictor never updates on a bubble.
- FlushD together with StallD: flush wins.
- Latency: one cycle F->D. Redirect penalty is exactly one bubble.
- Arithmetic: all PC adds are 32-bit modulo. 32'hFFFF_FFFC + 4 = 0. No alignment checks.
- Reset asserted mid-operation clears state immediately, independent of clk.

Optional Feature:
- Macro: FETCH_PC_STATS_EN.
- Defined: adds three 32-bit wrapping counters, each reset to 0, and output ports for them:
  - StatHits: +1 per cycle in which F/D captures with PCControls[0]=1.
  - StatMispred: +1 per cycle with c3 or c2.
  - StatJumpMiss: +1 per cycle with c1.
- Not defined: counters and ports are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h3000, no controls, 3 clocks -> PCF 3000→3004→3008→300C; PCD follows one cycle behind; ValidD=1 from the first capture.
- PCF=32'h3010 with PCControls=4'b0001 and PCCache=32'h3400 -> next PCF=32'h3400; PCD=32'h3010, HitD=1.
- D holds PCD=32'h3010, HitD=1, with PCControls=4'b1001 -> RedirectD=1; next PCF=32'h3014 (c3 beats HitF); F/D squashed (ValidD=0, HitD=0).
- PCControls=4'b0100 with PCBranchD=32'h3100 and StallF=1, StallD=0 -> PCF=32'h3100 despite stall; InstrD=NOP_INSTR.
- StallD=1 with PCControls=4'b0010 -> RedirectD=0, PCF/F-D hold; after StallD drops, redirect to PCJumpD occurs.
- Assert reset asynchronously between edges while ValidD=1 -> all outputs at reset values before the next edge; with FETCH_PC_STATS_EN, counters read 0.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage next-PC selection, PC register and F/D pipeline
// register. Decode-stage corrections (mispredicted taken, unpredicted branch,
// unpredicted jump) redirect fetch and squash the wrongly fetched instruction.
// Optional build macro FETCH_PC_STATS_EN adds three wrapping event counters
// (StatHits, StatMispred, StatJumpMiss) and their output ports.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [3:0]  PCControls,
    input  logic [31:0] PCCache,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] PCJumpD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        HitD,
    output logic        ValidD,
    output logic        RedirectD
`ifdef FETCH_PC_STATS_EN
    ,
    output logic [31:0] StatHits,
    output logic [31:0] StatMispred,
    output logic [31:0] StatJumpMiss
`endif
);

    logic        corr_ok;
    logic        c3, c2, c1;
    logic        hit_f;
    logic        capture_d;
    logic [31:0] pc_next;

    // A correction only counts when D holds a real instruction that is moving on.
    assign corr_ok   = ValidD & ~StallD;
    assign c3        = corr_ok & PCControls[3];
    assign c2        = corr_ok & PCControls[2];
    assign c1        = corr_ok & PCControls[1];
    assign hit_f     = PCControls[0];
    assign RedirectD = c3 | c2 | c1;
    assign PCPlus4F  = PCF + 32'd4;
    assign capture_d = ~RedirectD & ~FlushD & ~StallD;

    // Next-PC priority: decode corrections first, then predictor hit, then sequential.
    always_comb begin
        pc_next = PCPlus4F;
        if (c3)
            pc_next = PCPlus4D;
        else if (c2)
            pc_next = PCBranchD;
        else if (c1)
            pc_next = PCJumpD;
        else if (hit_f)
            pc_next = PCCache;
    end

    // PC register; a redirect must land even while fetch is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            PCF <= RESET_PC;
        else if (RedirectD || !StallF)
            PCF <= pc_next;
    end

    // F/D register; squashed slots carry HitD=0 so the predictor never trains on a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            HitD     <= 1'b0;
            ValidD   <= 1'b0;
        end else if (RedirectD || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            HitD     <= 1'b0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            HitD     <= hit_f;
            ValidD   <= 1'b1;
        end
    end

`ifdef FETCH_PC_STATS_EN
    // Event counters: predictor hits captured into D, taken mispredicts, missed jumps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StatHits     <= 32'd0;
            StatMispred  <= 32'd0;
            StatJumpMiss <= 32'd0;
        end else begin
            if (capture_d && hit_f)
                StatHits <= StatHits + 32'd1;
            if (c3 || c2)
                StatMispred <= StatMispred + 32'd1;
            if (c1)
                StatJumpMiss <= StatJumpMiss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed table-driven bench for fetch_pc_ctrl with
// RESET_PC=32'h3000, plus hand-written reset sequences.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic [3:0]  PCControls = 4'd0;
    logic [31:0] PCCache = 32'd0, PCBranchD = 32'd0, PCJumpD = 32'd0, InstrF = 32'd0;
    logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
    logic        HitD, ValidD, RedirectD;
`ifdef FETCH_PC_STATS_EN
    logic [31:0] StatHits, StatMispred, StatJumpMiss;
`endif

    fetch_pc_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCControls(PCControls), .PCCache(PCCache), .PCBranchD(PCBranchD),
        .PCJumpD(PCJumpD), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .HitD(HitD),
        .ValidD(ValidD), .RedirectD(RedirectD)
`ifdef FETCH_PC_STATS_EN
        , .StatHits(StatHits), .StatMispred(StatMispred), .StatJumpMiss(StatJumpMiss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sf, sd, fl;
        logic [3:0]  ctrl;
        logic [31:0] cache, br, jmp, instr;
        logic        e_redir;
        logic [31:0] e_pcf, e_pcd, e_instrd;
        logic        e_valid, e_hit;
    } vec_t;

    vec_t v[19];

    function automatic vec_t mk(logic sf, logic sd, logic fl, logic [3:0] ctrl,
                                logic [31:0] cache, logic [31:0] br, logic [31:0] jmp,
                                logic [31:0] instr, logic e_redir, logic [31:0] e_pcf,
                                logic [31:0] e_pcd, logic [31:0] e_instrd,
                                logic e_valid, logic e_hit);
        vec_t r;
        r.sf = sf; r.sd = sd; r.fl = fl; r.ctrl = ctrl; r.cache = cache;
        r.br = br; r.jmp = jmp; r.instr = instr; r.e_redir = e_redir;
        r.e_pcf = e_pcf; r.e_pcd = e_pcd; r.e_instrd = e_instrd;
        r.e_valid = e_valid; r.e_hit = e_hit;
        return r;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, ".PCF"}, PCF, RST_PC);
        check({tag, ".PCPlus4F"}, PCPlus4F, RST_PC + 32'd4);
        check({tag, ".InstrD"}, InstrD, NOP);
        check({tag, ".PCD"}, PCD, 32'd0);
        check({tag, ".PCPlus4D"}, PCPlus4D, 32'd0);
        check({tag, ".HitD"}, {31'd0, HitD}, 32'd0);
        check({tag, ".ValidD"}, {31'd0, ValidD}, 32'd0);
        check({tag, ".RedirectD"}, {31'd0, RedirectD}, 32'd0);
`ifdef FETCH_PC_STATS_EN
        check({tag, ".StatHits"}, StatHits, 32'd0);
        check({tag, ".StatMispred"}, StatMispred, 32'd0);
        check({tag, ".StatJumpMiss"}, StatJumpMiss, 32'd0);
`endif
    endtask

    initial begin
        //        sf  sd  fl  ctrl     cache         br            jmp           instr        redir pcf           pcd           instrD       val hit
        v[0]  = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h11, 0, 32'h3004,     32'h3000,     32'h11, 1, 0);
        v[1]  = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h22, 0, 32'h3008,     32'h3004,     32'h22, 1, 0);
        v[2]  = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h33, 0, 32'h300C,     32'h3008,     32'h33, 1, 0);
        v[3]  = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h44, 0, 32'h3010,     32'h300C,     32'h44, 1, 0);
        v[4]  = mk(0, 0, 0, 4'b0001, 32'h3400,     32'h0,        32'h0,        32'h55, 0, 32'h3400,     32'h3010,     32'h55, 1, 1);
        v[5]  = mk(0, 0, 0, 4'b1001, 32'h3800,     32'h0,        32'h0,        32'h66, 1, 32'h3014,     32'h0,        NOP,    0, 0);
        v[6]  = mk(0, 0, 0, 4'b0100, 32'h0,        32'h3100,     32'h0,        32'h77, 0, 32'h3018,     32'h3014,     32'h77, 1, 0);
        v[7]  = mk(1, 0, 0, 4'b0100, 32'h0,        32'h3100,     32'h0,        32'h88, 1, 32'h3100,     32'h0,        NOP,    0, 0);
        v[8]  = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h99, 0, 32'h3104,     32'h3100,     32'h99, 1, 0);
        v[9]  = mk(1, 1, 0, 4'b0010, 32'h0,        32'h0,        32'h3200,     32'hAA, 0, 32'h3104,     32'h3100,     32'h99, 1, 0);
        v[10] = mk(0, 0, 0, 4'b0010, 32'h0,        32'h0,        32'h3200,     32'hBB, 1, 32'h3200,     32'h0,        NOP,    0, 0);
        v[11] = mk(0, 1, 1, 4'b0000, 32'h0,        32'h0,        32'h0,        32'hCC, 0, 32'h3204,     32'h0,        NOP,    0, 0);
        v[12] = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'hDD, 0, 32'h3208,     32'h3204,     32'hDD, 1, 0);
        v[13] = mk(1, 1, 0, 4'b1000, 32'h0,        32'h0,        32'h0,        32'hD1, 0, 32'h3208,     32'h3204,     32'hDD, 1, 0);
        v[14] = mk(0, 0, 0, 4'b0001, 32'hFFFFFFFC, 32'h0,        32'h0,        32'hEE, 0, 32'hFFFFFFFC, 32'h3208,     32'hEE, 1, 1);
        v[15] = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'hFF, 0, 32'h0,        32'hFFFFFFFC, 32'hFF, 1, 0);
        v[16] = mk(0, 0, 0, 4'b1000, 32'h0,        32'h0,        32'h0,        32'h10, 1, 32'h0,        32'h0,        NOP,    0, 0);
        v[17] = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h12, 0, 32'h4,        32'h0,        32'h12, 1, 0);
        v[18] = mk(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h13, 0, 32'h8,        32'h4,        32'h13, 1, 0);

        #1 reset = 1'b1;
        #2;
        check_reset_state("rst0");
        repeat (2) @(posedge clk);
        #1 check_reset_state("rst_held");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (i != 0) @(negedge clk);
            StallF = v[i].sf; StallD = v[i].sd; FlushD = v[i].fl;
            PCControls = v[i].ctrl; PCCache = v[i].cache; PCBranchD = v[i].br;
            PCJumpD = v[i].jmp; InstrF = v[i].instr;
            #1 check({tag, ".RedirectD"}, {31'd0, RedirectD}, {31'd0, v[i].e_redir});
            @(posedge clk);
            #1;
            check({tag, ".PCF"}, PCF, v[i].e_pcf);
            check({tag, ".PCPlus4F"}, PCPlus4F, v[i].e_pcf + 32'd4);
            check({tag, ".PCD"}, PCD, v[i].e_pcd);
            check({tag, ".PCPlus4D"}, PCPlus4D, v[i].e_valid ? v[i].e_pcd + 32'd4 : 32'd0);
            check({tag, ".InstrD"}, InstrD, v[i].e_instrd);
            check({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v[i].e_valid});
            check({tag, ".HitD"}, {31'd0, HitD}, {31'd0, v[i].e_hit});
        end

`ifdef FETCH_PC_STATS_EN
        check("stat.hits", StatHits, 32'd2);
        check("stat.mispred", StatMispred, 32'd3);
        check("stat.jumpmiss", StatJumpMiss, 32'd1);
`endif

        // Mid-cycle asynchronous reset while D holds a valid instruction.
        PCControls = 4'b0000;
        check("pre_async.ValidD", {31'd0, ValidD}, 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_state("async");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.PCF", PCF, RST_PC + 32'd4);
        check("post_rst.PCD", PCD, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
